// File: rtl/rv_isa_pkg.sv
// RV32I format codes, opcodes, loader FSM states and the field-level encoder.
// imm_legal exists only in builds with ENC_IMM_CHECK_EN.
package rv_isa_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'b000,
    FMT_I    = 3'b001,
    FMT_LOAD = 3'b010,
    FMT_S    = 3'b011,
    FMT_B    = 3'b100,
    FMT_J    = 3'b101,
    FMT_U    = 3'b110,
    FMT_SYS  = 3'b111
  } fmt_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_e;

  function automatic logic [31:0] encode_instr(
    input fmt_e        fmt,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = '0;
    case (fmt)
      FMT_R:    w = {f7, rs2, rs1, f3, rd, OP_R};
      FMT_I:    w = {imm[11:0], rs1, f3, rd, OP_I};
      FMT_LOAD: w = {imm[11:0], rs1, f3, rd, OP_LOAD};
      FMT_S:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
      FMT_B:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_B};
      FMT_J:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
      FMT_U:    w = {imm[31:12], rd, OP_U};
      FMT_SYS:  w = {imm[11:0], rs1, f3, rd, OP_SYS};
    endcase
    return w;
  endfunction

`ifdef ENC_IMM_CHECK_EN
  // An immediate is legal when every bit above the field's sign bit is a copy of it.
  function automatic logic imm_legal(input fmt_e fmt, input logic [31:0] imm);
    logic ok;
    ok = 1'b1;
    case (fmt)
      FMT_I, FMT_LOAD, FMT_S, FMT_SYS: ok = (imm[31:11] == {21{imm[11]}});
      FMT_B:   ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
      FMT_J:   ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
      FMT_U:   ok = (imm[11:0] == 12'h000);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction
`endif

endpackage

// File: rtl/sync_fifo.sv
// DEPTH x W synchronous FIFO with show-ahead read; 1-cycle write-to-read latency.
// No internal backpressure: caller must not push when full or pop when empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign pop_dat = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field-level requests into RV32I words and streams them into imem; accept-to-write >= 1 cycle.
// Backpressure: req_ready drops when the FIFO is full or the session is draining. Option: ENC_IMM_CHECK_EN.
module instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_fmt,
  input  logic [2:0]        req_funct3,
  input  logic [6:0]        req_funct7,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-2:0] count
);
  localparam int LW = $clog2(DEPTH) + 1;

  state_e            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-2:0] cnt;
  logic              err_q;
  logic              full, empty;
  logic [LW-1:0]     level;
  logic [31:0]       enc_word, head;
  logic              accept, push, pop, clr, imm_bad, drain_done;

  assign enc_word = encode_instr(fmt_e'(req_fmt), req_funct3, req_funct7,
                                 req_rd, req_rs1, req_rs2, req_imm);

`ifdef ENC_IMM_CHECK_EN
  assign imm_bad = !imm_legal(fmt_e'(req_fmt), req_imm);
`else
  assign imm_bad = 1'b0;
`endif

  assign req_ready = (state == ST_LOAD) && !full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && !imm_bad;
  assign imem_we   = ((state == ST_LOAD) || (state == ST_DRAIN)) && !empty;
  assign pop       = imem_we && imem_ready;
  assign clr       = (state == ST_IDLE) && start;
  // Leave DRAIN on the edge that retires the final word so done follows it by one cycle.
  assign drain_done = empty || (pop && (level == LW'(1)));

  sync_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push     (push),
    .push_dat (enc_word),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      addr  <= BASE_ADDR;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (pop) begin
        addr <= addr + ADDR_W'(4);
        cnt  <= cnt + (ADDR_W-1)'(1);
      end
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_LOAD;
          addr  <= BASE_ADDR;
          cnt   <= '0;
          err_q <= 1'b0;
        end
        ST_LOAD: begin
          if (accept && imm_bad)  err_q <= 1'b1;
          if (accept && req_last) state <= ST_DRAIN;
        end
        ST_DRAIN: if (drain_done) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign imem_addr  = addr;
  assign imem_wdata = imem_we ? head : 32'h0;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign err        = err_q;
  assign count      = cnt;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with an expected-write queue model.
module tb_instr_encoder_loader;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic              req_valid = 1'b0, req_last = 1'b0, imem_ready = 1'b1;
  logic [2:0]        req_fmt = '0, req_funct3 = '0;
  logic [6:0]        req_funct7 = '0;
  logic [4:0]        req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0]       req_imm = '0;
  logic              req_ready, imem_we, busy, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W-2:0] count;

  always #5 clk = ~clk;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(10'h000)) dut (
    .clk(clk), .rst(rst), .start(start), .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .req_last(req_last), .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .err(err), .count(count)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t               q[$];
  wr_t               w;
  logic [ADDR_W-1:0] model_addr = '0;
  int                model_cnt = 0;
  bit                model_err = 0, last_sent = 0, done_free = 0, chk_en = 0;
  bit                done_due = 0, prev_stall = 0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [31:0]       prev_data = '0;
  int                n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference packing from the field layout, using shifts and masks on the immediate value.
  function automatic logic [31:0] m_enc(input logic [2:0] fmt, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
    logic [31:0] base, op;
    base = (32'(rs1) << 15) | (32'(f3) << 12);
    case (fmt)
      3'd0: return (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7) | 32'h33;
      3'd1, 3'd2, 3'd7: begin
        op = (fmt == 3'd1) ? 32'h13 : (fmt == 3'd2) ? 32'h03 : 32'h73;
        return ((imm & 32'hfff) << 20) | base | (32'(rd) << 7) | op;
      end
      3'd3: return (((imm >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | base |
                   ((imm & 32'h1f) << 7) | 32'h23;
      3'd4: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) |
                   (32'(rs2) << 20) | base | (((imm >> 1) & 32'hf) << 8) |
                   (((imm >> 11) & 32'h1) << 7) | 32'h63;
      3'd5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21) |
                   (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hff) << 12) |
                   (32'(rd) << 7) | 32'h6f;
      default: return (imm & 32'hfffff000) | (32'(rd) << 7) | 32'h37;
    endcase
  endfunction

  function automatic bit m_legal(input logic [2:0] fmt, input logic [31:0] imm);
`ifdef ENC_IMM_CHECK_EN
    int s;
    s = $signed(imm);
    case (fmt)
      3'd1, 3'd2, 3'd3, 3'd7: return (s >= -2048) && (s <= 2047);
      3'd4: return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      3'd5: return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
      3'd6: return (imm & 32'hfff) == 32'h0;
      default: return 1'b1;
    endcase
`else
    return 1'b1;
`endif
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_addr = '0;
    model_cnt  = 0;
    model_err  = 0;
    last_sent  = 0;
  endtask

  task automatic send(input string nm, input logic [2:0] fmt, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input bit last,
                      input logic [31:0] exp_w);
    logic [31:0] wd;
    bit ok, got;
    wd = m_enc(fmt, f3, f7, rd, rs1, rs2, imm);
    if (exp_w != 32'h0) begin
      chk({"model_", nm}, wd, exp_w);
      wd = exp_w;
    end
    ok = m_legal(fmt, imm);
    req_fmt = fmt; req_funct3 = f3; req_funct7 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_last = last; req_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (got) begin
      @(posedge clk); #1;
    end else begin
      chk({"accept_", nm}, 32'(got), 32'h1);
    end
    req_valid = 1'b0;
    req_last  = 1'b0;
    if (got) begin
      if (ok) begin
        q.push_back({model_addr, wd});
        model_addr = model_addr + 10'd4;
      end else begin
        model_err = 1;
      end
      if (last) last_sent = 1;
    end
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({nm, "_done"}, 32'(seen), 32'h1);
  endtask

  // Per-cycle comparison against the model's write queue and session flags.
  always @(negedge clk) begin
    if (!chk_en) begin
      prev_stall = 0;
      done_due   = 0;
    end else begin
      chk("we_vs_queue", 32'(imem_we), 32'(q.size() != 0));
      chk("count", 32'(count), 32'(model_cnt));
      chk("err", 32'(err), 32'(model_err));
      if (!done_free) chk("done", 32'(done), 32'(done_due));
      if (imem_we && prev_stall) begin
        chk("stall_addr", 32'(imem_addr), 32'(prev_addr));
        chk("stall_data", imem_wdata, prev_data);
      end
      done_due = 0;
      if (imem_we && imem_ready && q.size() != 0) begin
        w = q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(w.a));
        chk("wr_data", imem_wdata, w.d);
        model_cnt++;
        if (q.size() == 0 && last_sent) done_due = 1;
      end
      prev_stall = imem_we && !imem_ready;
      prev_addr  = imem_addr;
      prev_data  = imem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_imem_we", 32'(imem_we), 32'h0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h0);
    chk("rst_imem_wdata", imem_wdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1;
    idle(2);

    // single addi
    do_start();
    send("addi", 3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h00500093);
    wait_done("t1");
    idle(1);
    chk("t1_count", 32'(count), 32'h1);
    chk("t1_busy", 32'(busy), 32'h0);

    // add then sw
    do_start();
    send("add", 3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 32'h002081B3);
    send("sw", 3'd3, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1, 32'h0020A423);
    wait_done("t2");

    // beq -4 then lui
    do_start();
    send("beq", 3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 0, 32'hFE208EE3);
    send("lui", 3'd6, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1, 32'h123452B7);
    wait_done("t3");

    // fill the FIFO against a stalled memory, then release it
    imem_ready = 1'b0;
    do_start();
    send("lw", 3'd2, 3'd2, 7'd0, 5'd4, 5'd2, 5'd0, 32'hFFFFFFF8, 0, 32'hFF812203);
    send("ecall", 3'd7, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'h00000073);
    send("jal", 3'd5, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 0, 32'h008000EF);
    send("andi", 3'd1, 3'd7, 7'd0, 5'd1, 5'd1, 5'd0, 32'h7FF, 0, 32'h7FF0F093);
    @(negedge clk);
    chk("full_req_ready", 32'(req_ready), 32'h0);
    chk("full_busy", 32'(busy), 32'h1);
    idle(2);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(1);
    imem_ready = 1'b1;
    send("sub", 3'd0, 3'd0, 7'h20, 5'd7, 5'd5, 5'd6, 32'd0, 1, 32'h406283B3);
    wait_done("t4");
    idle(1);
    chk("t4_count", 32'(count), 32'h5);

    // back-to-back mixed formats, including immediates at range edges
    do_start();
    send("jal_neg", 3'd5, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'hFFFFF800, 0, 32'h0);
    send("bne_max", 3'd4, 3'd1, 7'd0, 5'd0, 5'd3, 5'd4, 32'd4094, 0, 32'h0);
    send("sb_m1", 3'd3, 3'd0, 7'd0, 5'd0, 5'd8, 5'd9, 32'hFFFFFFFF, 0, 32'h0);
    send("lui_top", 3'd6, 3'd0, 7'd0, 5'd31, 5'd0, 5'd0, 32'hFFFFF000, 0, 32'h0);
    send("addi_wide", 3'd1, 3'd0, 7'd0, 5'd10, 5'd11, 5'd0, 32'h00001005, 0, 32'h0);
    send("csr", 3'd7, 3'd1, 7'd0, 5'd12, 5'd13, 5'd0, 32'h00000305, 1, 32'h0);
    wait_done("t5");

`ifdef ENC_IMM_CHECK_EN
    // out-of-range immediate is accepted but dropped, err is sticky until start
    do_start();
    done_free = 1;
    send("addi_2048", 3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1, 32'h0);
    wait_done("t6");
    idle(1);
    done_free = 0;
    chk("t6_err", 32'(err), 32'h1);
    chk("t6_count", 32'(count), 32'h0);
    do_start();
    chk("t6_err_clr", 32'(err), 32'h0);
    send("addi_ok", 3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2047, 1, 32'h0);
    wait_done("t6b");
`endif

    // reset with two words queued
    imem_ready = 1'b0;
    do_start();
    send("q0", 3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 0, 32'h0);
    send("q1", 3'd1, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2, 0, 32'h0);
    rst = 1'b1;
    chk_en = 0;
    @(negedge clk);
    chk("mid_rst_we", 32'(imem_we), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_addr", 32'(imem_addr), 32'h0);
    chk("mid_rst_count", 32'(count), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    model_cnt = 0; model_err = 0; last_sent = 0; model_addr = '0;
    imem_ready = 1'b1;
    chk_en = 1;
    idle(10);
    chk("post_rst_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential instruction encoder and instruction-memory loader for the single-cycle RV32 core. It accepts field-level instruction requests through a valid/ready handshake and packs each one into a 32-bit RV32I word, the inverse of the main control decoder's opcode mapping. It buffers encoded words in a small FIFO and writes them into instruction memory at consecutive word addresses. It sits between the testbench/boot host and the instruction memory's write port.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- ADDR_W, 10: instruction-memory byte-address width
- BASE_ADDR, 0: first write address after `start` (word-aligned)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse that begins a load session
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready at rising edge
- req_fmt  in  3  000 R, 001 I, 010 LOAD, 011 S, 100 B, 101 J, 110 U, 111 SYS
- req_funct3  in  3  funct3 field
- req_funct7  in  7  funct7 field (R only)
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  32  signed immediate (U: full value, low 12 bits ignored)
- req_last  in  1  marks final request of session
- imem_we  out  1  write strobe
- imem_ready  in  1  memory accepts write this cycle
- imem_addr  out  ADDR_W  byte address
- imem_wdata  out  32  encoded word
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky error (see Configuration)
- count  out  ADDR_W-1  words written this session

## Operation
- Opcodes: R 0110011, I 0010011, LOAD 0000011, S 0100011, B 1100011, J 1101111, U 0110111, SYS 1110011.
- Packing: R funct7|rs2|rs1|f3|rd|op; I/LOAD/SYS imm[11:0]|rs1|f3|rd|op; S imm[11:5]|rs2|rs1|f3|imm[4:0]|op; B imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op; J imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op; U imm[31:12]|rd|op. Unused fields are ignored.
- FSM states:
  - IDLE: `start` → LOAD. On entry to LOAD: address ← BASE_ADDR, count ← 0, err ← 0, FIFO cleared.
  - LOAD: req_ready = !full. An accepted request with req_last → DRAIN.
  - DRAIN: req_ready = 0. FIFO empty and no write in progress → DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- A `start` outside IDLE is ignored.
- Write side: imem_we = !empty in LOAD or DRAIN. A write completes when imem_we&imem_ready; the FIFO pops, address += 4 (wraps modulo 2^ADDR_W), and count increments.
- Simultaneous push and pop while full is not possible, because ready is low when full. Push and pop in the same cycle otherwise keep occupancy unchanged.
- `rst` mid-session: everything returns to reset values immediately and FIFO contents are discarded.

## Timing
- Reset values: req_ready 0, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, busy 0, done 0, err 0, count 0, state IDLE.
- Encoding is combinational into the FIFO write; the word is stored at the accepting edge.
- Earliest imem_we is the cycle after acceptance. Minimum latency from acceptance to memory write is 1 cycle.
- Sustained throughput is one word per cycle with imem_ready held high.
- imem_addr and imem_wdata are stable while imem_we=1 and imem_ready=0.
- done asserts exactly one cycle after the last write completes.

## Configuration
- `ENC_IMM_CHECK_EN` defined: immediates are range-checked. Legal ranges: I/LOAD/S/SYS −2048..2047; B −4096..4094 and even; J ±1 MiB and even; U low 12 bits zero. A violating request is still accepted but is not pushed, and err sets (sticky until next start). req_last on a dropped request still moves the FSM to DRAIN.
- Undefined: no checks are made; immediate bits are truncated silently and err stays 0.

## Structure
- Shared package `rv_isa_pkg`: fmt enum (same 3-bit codes as the control decoder's ALUOp), the 8 opcode constants, and the FSM state typedef.
- One sub-module `sync_fifo` (DEPTH×32, full/empty flags).
- The encoder is a function in the package; the top level holds the FSM, address counter and counter.

## Test plan
- start; I addi rd=1 rs1=0 f3=0 imm=5, last → imem_wdata 0x00500093 at addr 0x000, done one cycle later, count 1.
- R add rd=3 rs1=1 rs2=2 f3=0 f7=0, then S sw rs1=1 rs2=2 f3=010 imm=8, last → 0x002081B3 @0x000, 0x0020A423 @0x004.
- B beq rs1=1 rs2=2 imm=−4 → 0xFE208EE3; U lui rd=5 imm=0x12345000 → 0x123452B7.
- imem_ready held 0, DEPTH=4: 4 requests accepted, then req_ready=0. Release imem_ready → 4 consecutive writes, with address/data held stable during the stall.
- With `ENC_IMM_CHECK_EN`: I imm=2048 → no write, err=1, count 0; next start clears err.
- Assert rst while 2 words are queued → imem_we=0, busy=0, and no further writes after release.
